muldiv_unit: RTL

//  Iterative RV32M multiply/divide execution unit. It sits directly downstream of the register file,

---
 rtl/muldiv_if.sv | 27 ++
 rtl/muldiv_unit.sv | 113 +++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
// muldiv_if: issue/result bundle between the core and the RV32M multiply/divide unit
//   master (core): start, kill, funct3, op_a, op_b, rd_in out; busy, done, result, rd_out in
//   slave  (unit): the same signals with the directions reversed
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            kill;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, kill, funct3, op_a, op_b, rd_in,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, kill, funct3, op_a, op_b, rd_in,
        output busy, done, result, rd_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, one shift-add/shift-subtract step per cycle
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : muldiv_if slave (start/kill/funct3/op_a/op_b/rd_in in; busy/done/result/rd_out out)
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input logic     clk,
    input logic     reset,
    muldiv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   m_q;
    logic [2*XLEN-1:0] acc_q;
    logic              nq_q, nr_q;
    logic              busy_q, done_q;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        rd_out_q;

    logic              sa, sb, is_div, special;
    logic [XLEN-1:0]   mag_a, mag_b, spec_res, fin;
    logic [XLEN:0]     sum, sh, diff;
    logic [2*XLEN-1:0] acc_d, prod;

    always_comb begin
        // a is signed except for MULHU/DIVU/REMU; b is signed only for MUL/MULH/DIV/REM
        sa       = bus.op_a[XLEN-1] & ~(bus.funct3[0] & (bus.funct3[1] | bus.funct3[2]));
        sb       = bus.op_b[XLEN-1] & (bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1]);
        mag_a    = sa ? -bus.op_a : bus.op_a;
        mag_b    = sb ? -bus.op_b : bus.op_b;
        is_div   = bus.funct3[2];
        special  = is_div & ((bus.op_b == '0) |
                   (~bus.funct3[0] & (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) & (bus.op_b == '1)));
        // signed overflow returns op_a itself (0x80000000) for DIV and 0 for REM
        spec_res = (bus.op_b == '0) ? (bus.funct3[1] ? bus.op_a : '1)
                                    : (bus.funct3[1] ? '0 : bus.op_a);
        // multiply: {hi,lo} holds {partial product, remaining multiplier bits}
        sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
        // divide: {hi,lo} holds {partial remainder, dividend bits then quotient bits}
        sh       = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff     = sh - {1'b0, m_q};
        acc_d    = ~op_q[2] ? {sum, acc_q[XLEN-1:1]}
                 : diff[XLEN] ? {sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                              : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        prod     = nq_q ? -acc_d : acc_d;
        fin      = op_q[2] ? (op_q[1] ? (nr_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN])
                                      : (nq_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0]))
                           : (op_q[1:0] == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            m_q      <= '0;
            acc_q    <= '0;
            nq_q     <= 1'b0;
            nr_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else if (bus.kill) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (state_q == CALC) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(XLEN-1)) begin
                state_q  <= DONE;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                result_q <= fin;
                rd_out_q <= rd_q;
            end
        end else if (bus.start) begin
            op_q <= bus.funct3;
            rd_q <= bus.rd_in;
            nq_q <= sa ^ sb;
            nr_q <= sa;
            if (special) begin
                state_q  <= DONE;
                done_q   <= 1'b1;
                result_q <= spec_res;
                rd_out_q <= bus.rd_in;
            end else begin
                state_q <= CALC;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
                cnt_q   <= '0;
                m_q     <= is_div ? mag_b : mag_a;
                acc_q   <= {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
            end
        end else begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;
endmodule
